// File: rtl/riscv_fetch_queue_pkg.sv
// riscv_fetch_queue_pkg: shared widths, reset PC and fetch packet types for the fetch front end
package riscv_fetch_queue_pkg;
    localparam int DEFAULT_XLEN = 32;
    localparam logic [DEFAULT_XLEN-1:0] DEFAULT_RESET_PC = '0;
    typedef logic [DEFAULT_XLEN-1:0] inst_t;
    typedef struct packed {
        logic [DEFAULT_XLEN-1:0] pc;
        inst_t                   inst;
    } fetch_pkt_t;
endpackage

// File: rtl/riscv_fetch_queue_if.sv
// riscv_fetch_queue_if: redirect, imem request/response and instruction output channels
//   master: the fetch queue (drives imem requests and instructions)
//   slave:  memory + downstream hart (drives ready, responses and redirects)
interface riscv_fetch_queue_if import riscv_fetch_queue_pkg::*; #(parameter int XLEN = DEFAULT_XLEN) ();
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_resp_valid;
    logic [XLEN-1:0] imem_resp_data;
    logic            inst_valid;
    logic            inst_ready;
    logic [XLEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;
    modport master (
        input  redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
    modport slave (
        output redirect, redirect_pc, imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc
    );
endinterface

// File: rtl/riscv_fetch_queue_fifo.sv
// riscv_fetch_queue_fifo: synchronous FIFO with flush and occupancy count
//   clk/rst: clock, async active-high reset; flush: empty the FIFO (wins over push)
//   push/din: write; pop: read (ignored when empty); dout: head entry; count: occupancy
module riscv_fetch_queue_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_pop;
    assign do_pop = pop && count != '0;
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or posedge rst) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
            count  <= count + CW'(push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/riscv_fetch_queue.sv
// riscv_fetch_queue: sequential instruction fetch with credit-limited requests, PC tagging and redirect flush
//   clk/rst: clock, async active-high reset
//   bus (master): redirect/redirect_pc in, imem request out / response in, {inst_pc, inst_data} valid/ready out
module riscv_fetch_queue import riscv_fetch_queue_pkg::*; #(
    parameter int              XLEN     = DEFAULT_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC),
    localparam int             CW       = $clog2(DEPTH) + 1
) (
    input logic                 clk,
    input logic                 rst,
    riscv_fetch_queue_if.master bus
);
    logic              started;
    logic [XLEN-1:0]   fetch_pc, tag_pc;
    logic [CW-1:0]     outstanding, drop, count, tag_count;
    logic [CW:0]       credit_used;
    logic [2*XLEN-1:0] head;
    logic              req_fire, resp_keep, inst_fire;
    // Outstanding plus buffered never exceeds DEPTH, so every response has a slot waiting.
    assign credit_used        = {1'b0, outstanding} + {1'b0, count};
    assign bus.imem_req_valid = started && !bus.redirect && credit_used < (CW+1)'(DEPTH);
    assign bus.imem_req_addr  = fetch_pc;
    assign req_fire           = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_keep          = bus.imem_resp_valid && drop == '0 && !bus.redirect;
    assign bus.inst_valid     = count != '0;
    assign inst_fire          = bus.inst_valid && bus.inst_ready && !bus.redirect;
    assign {bus.inst_pc, bus.inst_data} = bus.inst_valid ? head : '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            started     <= 1'b0;
            fetch_pc    <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
        end else begin
            started     <= 1'b1;
            fetch_pc    <= bus.redirect ? bus.redirect_pc & ~XLEN'(3) : req_fire ? fetch_pc + XLEN'(4) : fetch_pc;
            outstanding <= outstanding + CW'(req_fire) - CW'(bus.imem_resp_valid);
            // After a redirect every response still in flight is stale, including ones already
            // marked for dropping, so the drop count becomes the whole in-flight count.
            drop        <= bus.redirect ? outstanding - CW'(bus.imem_resp_valid)
                                        : drop - CW'(bus.imem_resp_valid && drop != '0);
        end
    end
    riscv_fetch_queue_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag (
        .clk(clk), .rst(rst), .flush(bus.redirect), .push(req_fire), .pop(resp_keep),
        .din(fetch_pc), .dout(tag_pc), .count(tag_count)
    );
    riscv_fetch_queue_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst (
        .clk(clk), .rst(rst), .flush(bus.redirect), .push(resp_keep), .pop(inst_fire),
        .din({tag_pc, bus.imem_resp_data}), .dout(head), .count(count)
    );
    a_counters: assert property (@(posedge clk) disable iff (rst)
        count <= CW'(DEPTH) && outstanding <= CW'(DEPTH) && drop <= outstanding && tag_count <= outstanding);
endmodule
